// File: rtl/pulse_meter_pkg.sv
// Shared types and helpers for the pulse period meter.
//   meter_state_t : measurement FSM state encoding
//   sat_inc       : increment that sticks at a ceiling value
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_LOCKED
    } meter_state_t;

    function automatic int unsigned sat_inc(input int unsigned v, input int unsigned max);
        return (v >= max) ? max : v + 1;
    endfunction

endpackage

// File: rtl/rising_edge_detect.sv
// Rising-edge detector for an already-synchronous input.
// The history register updates every cycle regardless of any enable in the
// consumer, so a level that rose while the consumer was frozen is not seen
// as a fresh edge once it resumes.
//   clk        : system clock
//   rst        : synchronous active-low reset
//   in         : synchronous input level
//   pulse_edge : high for the cycle in which 'in' goes 0 -> 1
module rising_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic pulse_edge
);

    logic prev_in;

    always_ff @(posedge clk) begin
        if (!rst) prev_in <= 1'b0;
        else      prev_in <= in;
    end

    assign pulse_edge = in & ~prev_in;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures the interval, in clk cycles, between rising edges on pulse_in,
// declares lock after LOCK_COUNT consecutive matching intervals and strobes
// timeout when no edge arrives within MAX = 2^N-1 cycles.
// Build option: define PULSE_METER_JITTER_EN to accept intervals within
// +/-1 cycle of the previous one as matching (default: exact match).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no reference edge yet; waiting for the first edge
// S_MEASURE | counting intervals, building a run of matching intervals
// S_LOCKED  | run reached LOCK_COUNT; any mismatch drops back to S_MEASURE
//
// Ports:
//   clk          : system clock
//   rst          : synchronous active-low reset
//   ena          : 1 = measure, 0 = freeze all measurement state
//   pulse_in     : synchronous pulse stream (rising edges counted)
//   period       : most recent measured interval
//   period_valid : one-cycle strobe, period updated
//   locked       : LOCK_COUNT consecutive matching intervals seen
//   timeout      : one-cycle strobe, no edge within MAX cycles
module pulse_period_meter
    import pulse_meter_pkg::*;
#(
    parameter int N          = 8,
    parameter int LOCK_COUNT = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pulse_in,
    output logic [N-1:0] period,
    output logic         period_valid,
    output logic         locked,
    output logic         timeout
);

    localparam logic [N-1:0] MAX      = {N{1'b1}};
    localparam int unsigned  MAX_I    = (1 << N) - 1;
    localparam logic [N-1:0] LOCK_THR = N'(LOCK_COUNT);

    logic         pulse_edge;
    meter_state_t state;
    logic [N-1:0] cnt;
    logic [N-1:0] match_cnt;
    logic         interval_match;
    logic [N-1:0] match_next;

    rising_edge_detect u_edge (
        .clk        (clk),
        .rst        (rst),
        .in         (pulse_in),
        .pulse_edge (pulse_edge)
    );

`ifdef PULSE_METER_JITTER_EN
    localparam logic [N:0] ONE_W = (N+1)'(1);
    logic [N:0] diff;
    // Extra bit keeps the difference from wrapping near MAX.
    assign diff = (cnt >= period) ? ({1'b0, cnt} - {1'b0, period})
                                  : ({1'b0, period} - {1'b0, cnt});
    assign interval_match = (diff <= ONE_W);
`else
    assign interval_match = (cnt == period);
`endif

    // match_cnt==0 means no earlier interval in this run, so the first
    // interval after IDLE always starts a fresh run of 1.
    assign match_next = (match_cnt != '0 && interval_match)
                        ? N'(sat_inc(32'(match_cnt), MAX_I))
                        : N'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (ena) begin
                if (pulse_edge) cnt <= N'(1);
                else            cnt <= N'(sat_inc(32'(cnt), MAX_I));

                case (state)
                    S_IDLE: begin
                        if (pulse_edge) state <= S_MEASURE;
                    end
                    S_MEASURE: begin
                        if (pulse_edge) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            match_cnt    <= match_next;
                            if (match_next >= LOCK_THR) begin
                                locked <= 1'b1;
                                state  <= S_LOCKED;
                            end
                        end else if (cnt == MAX) begin
                            timeout   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            state     <= S_IDLE;
                        end
                    end
                    S_LOCKED: begin
                        if (pulse_edge) begin
                            period       <= cnt;
                            period_valid <= 1'b1;
                            if (interval_match) begin
                                match_cnt <= match_next;
                            end else begin
                                locked    <= 1'b0;
                                match_cnt <= N'(1);
                                state     <= S_MEASURE;
                            end
                        end else if (cnt == MAX) begin
                            timeout   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            state     <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter (N=8, LOCK_COUNT=3).
// A timestamp-based reference model predicts every output each cycle;
// directed tables and sequences add explicit expectations on top.
module tb_pulse_period_meter;

    localparam int N          = 8;
    localparam int LOCK_COUNT = 3;
    localparam int MAX        = (1 << N) - 1;

    logic         clk;
    logic         rst;
    logic         ena;
    logic         pulse_in;
    logic [N-1:0] period;
    logic         period_valid;
    logic         locked;
    logic         timeout;

    int n_checks;
    int n_errors;

    pulse_period_meter #(.N(N), .LOCK_COUNT(LOCK_COUNT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .pulse_in     (pulse_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: interval = number of enabled cycles between edges.
    int unsigned en_cyc;
    int unsigned last_en;
    bit          m_active;
    bit          m_prev;
    bit          m_valid;
    bit          m_to;
    bit          m_locked;
    int          m_period;
    int          m_runs;

    function automatic bit intervals_match(input int a, input int b);
`ifdef PULSE_METER_JITTER_EN
        return ((a > b) ? a - b : b - a) <= 1;
`else
        return a == b;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          e;
        int unsigned gap;
        if (!rst) begin
            m_active = 0; m_prev = 0; m_valid = 0; m_to = 0;
            m_locked = 0; m_period = 0; m_runs = 0;
        end else begin
            e       = pulse_in && !m_prev;
            m_prev  = pulse_in;
            m_valid = 0;
            m_to    = 0;
            if (ena) begin
                en_cyc++;
                if (m_active) begin
                    gap = en_cyc - last_en;
                    if (e) begin
                        m_valid = 1;
                        if (m_locked && !intervals_match(int'(gap), m_period)) begin
                            m_locked = 0;
                            m_runs   = 1;
                        end else begin
                            m_runs = (m_runs > 0 && intervals_match(int'(gap), m_period)) ? m_runs + 1 : 1;
                            if (m_runs >= LOCK_COUNT) m_locked = 1;
                        end
                        m_period = int'(gap);
                    end else if (gap >= MAX) begin
                        m_to = 1; m_locked = 0; m_runs = 0; m_active = 0;
                    end
                end else if (e) begin
                    m_active = 1;
                end
                if (e) last_en = en_cyc;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model period",       32'(period),       32'(m_period));
        chk("model period_valid", 32'(period_valid), 32'(m_valid));
        chk("model locked",       32'(locked),       32'(m_locked));
        chk("model timeout",      32'(timeout),      32'(m_to));
    endtask

    // Low for gap-1 cycles, then a one-cycle pulse; outputs then reflect it.
    task automatic edge_after(input int gap);
        pulse_in = 1'b0;
        repeat (gap - 1) tick();
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
    endtask

    typedef struct {
        int gap;
        bit valid;
        int period;
        bit locked;
        bit locked_jit;
    } vec_t;

    vec_t vecs [9];

    task automatic rnd_tick();
        ena = ($urandom_range(0, 19) != 0);
        rst = ($urandom_range(0, 399) != 0);
        tick();
    endtask

    initial begin
        int base;
        int p;
        int r;
        int w;
        bit exp_l;

        n_checks = 0; n_errors = 0;
        en_cyc = 0; last_en = 0;
        rst = 1'b0; ena = 1'b1; pulse_in = 1'b0;

        vecs[0] = '{4,  0, 0,  0, 0};
        vecs[1] = '{10, 1, 10, 0, 0};
        vecs[2] = '{10, 1, 10, 0, 0};
        vecs[3] = '{10, 1, 10, 1, 1};
        vecs[4] = '{10, 1, 10, 1, 1};
        vecs[5] = '{11, 1, 11, 0, 1};
        vecs[6] = '{10, 1, 10, 0, 1};
        vecs[7] = '{10, 1, 10, 0, 1};
        vecs[8] = '{10, 1, 10, 1, 1};

        // Reset with pulse_in toggling.
        pulse_in = 1'b1; tick();
        pulse_in = 1'b0; tick();
        chk("reset period",       32'(period),       0);
        chk("reset period_valid", 32'(period_valid), 0);
        chk("reset locked",       32'(locked),       0);
        chk("reset timeout",      32'(timeout),      0);
        rst = 1'b1;

        // Steady intervals, lock, single-interval disturbance, relock.
        for (int i = 0; i < 9; i++) begin
            edge_after(vecs[i].gap);
`ifdef PULSE_METER_JITTER_EN
            exp_l = vecs[i].locked_jit;
`else
            exp_l = vecs[i].locked;
`endif
            chk($sformatf("vec%0d valid", i),  32'(period_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d period", i), 32'(period),       32'(vecs[i].period));
            chk($sformatf("vec%0d locked", i), 32'(locked),       32'(exp_l));
        end

        // Pulses stop: timeout strobe MAX cycles after last edge.
        repeat (MAX - 1) tick();
        chk("no early timeout", 32'(timeout), 0);
        tick();
        chk("timeout strobe", 32'(timeout), 1);
        chk("timeout unlock", 32'(locked),  0);
        tick();
        chk("timeout one cycle", 32'(timeout), 0);
        edge_after(5);
        chk("idle edge no valid", 32'(period_valid), 0);

        // Edge exactly at cnt==MAX is a measurement, not a timeout.
        edge_after(MAX);
        chk("max interval valid",   32'(period_valid), 1);
        chk("max interval period",  32'(period),       MAX);
        chk("max interval timeout", 32'(timeout),      0);

        // Minimum interval 2, then a long-held pulse counting once.
        edge_after(2);
        chk("min interval period", 32'(period), 2);
        pulse_in = 1'b1;
        repeat (19) tick();
        chk("held high no valid", 32'(period_valid), 0);
        edge_after(10);
        chk("held high period", 32'(period), 29);

        // Freeze mid-interval with a pulse during the freeze.
        repeat (4) tick();
        ena = 1'b0;
        repeat (3) tick();
        pulse_in = 1'b1; tick();
        pulse_in = 1'b0;
        repeat (3) tick();
        chk("freeze period held", 32'(period),       29);
        chk("freeze no valid",    32'(period_valid), 0);
        ena = 1'b1;
        edge_after(6);
        chk("post-freeze period", 32'(period), 10);

        // Reset mid-interval restarts from IDLE.
        repeat (3) tick();
        rst = 1'b0; tick();
        rst = 1'b1;
        edge_after(2);
        chk("post-reset edge no valid", 32'(period_valid), 0);
        chk("post-reset period",        32'(period),       0);
        edge_after(7);
        chk("post-reset first period", 32'(period), 7);

        // Randomized traffic against the reference model.
        base = 12;
        for (int s = 0; s < 90; s++) begin
            if (s % 15 == 0) base = $urandom_range(4, 30);
            r = $urandom_range(0, 9);
            if (r < 5)      p = base;
            else if (r < 6) p = base + 1;
            else if (r < 7) p = base - 1;
            else if (r < 9) p = $urandom_range(2, 40);
            else            p = $urandom_range(240, 300);
            w = (p > 3) ? $urandom_range(1, 2) : 1;
            pulse_in = 1'b1;
            for (int i = 0; i < w; i++) rnd_tick();
            pulse_in = 1'b0;
            for (int i = w; i < p; i++) rnd_tick();
        end
        rst = 1'b1; ena = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pulse_period_meter.md
Name: pulse_period_meter

Overview:
Receive-side counterpart of the periodic tick generator. Measures the interval, in clk cycles, between rising edges on pulse_in. Reports each interval. Declares lock after a run of identical intervals and flags a timeout when pulses stop. Used to check or recover tick rates produced elsewhere in the design, such as LED/PWM timebases and display refresh strobes.

Parameters:
N, 8, width of the interval counter and the period output; MAX = 2^N-1.
LOCK_COUNT, 3, number of consecutive equal intervals required to assert locked (1..2^N-1).

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  synchronous, active-low reset (rst==0 resets on the next posedge).
ena  input  1  1 = measure; 0 = freeze all state (pulse edges ignored).
pulse_in  input  1  synchronous pulse stream; only rising edges count.
period  output  N  most recent measured interval, held between updates.
period_valid  output  1  one-cycle strobe: period updated this cycle.
locked  output  1  LOCK_COUNT consecutive equal intervals seen, no mismatch since.
timeout  output  1  one-cycle strobe: no edge within MAX cycles.

Behaviour:
- Reset (rst==0): period=0, period_valid=0, locked=0, timeout=0, cnt=0, match_cnt=0, prev_in=0, state=IDLE. Reset mid-measurement discards the partial interval.
- Edge detect: edge = pulse_in & ~prev_in; prev_in <= pulse_in every cycle, including when ena=0. This prevents a false edge after un-freeze.
- ena=0: cnt, match_cnt, state, period and locked hold. period_valid=0 and timeout=0.
- Counter: on an edge, cnt <= 1. Otherwise cnt <= cnt+1, saturating at MAX. With edges in cycles k and k+P, cnt==P in cycle k+P.
- States:
  - IDLE: on edge, cnt<=1 and go to MEASURE; no period_valid.
  - MEASURE: on edge, period<=cnt and period_valid<=1 in the following cycle (latency 1). Then:
    - if cnt==period (previous value) and a previous interval exists, match_cnt<=match_cnt+1, saturating;
    - otherwise match_cnt<=1.
    - When match_cnt reaches LOCK_COUNT, go to LOCKED and set locked<=1 in the same update.
  - LOCKED: the same measurement occurs on each edge. On a mismatch, locked<=0, match_cnt<=1, and go to MEASURE.
- Timeout: in MEASURE or LOCKED, with cnt==MAX and no edge, timeout<=1 for one cycle, locked<=0, match_cnt<=0, and go to IDLE. No timeout is generated in IDLE.
- An edge coincident with cnt==MAX is a valid measurement of period=MAX, not a timeout.
- Minimum measurable interval is 2, because rising edges need a low cycle between them. A pulse held high for many cycles counts once.
- The first interval after IDLE has no predecessor, so it sets match_cnt=1. With LOCK_COUNT=1, locked asserts on that first interval.

Optional Feature:
Macro PULSE_METER_JITTER_EN.
- Defined: an interval "matches" when |cnt - period| <= 1, computed at N+1 bits so there is no wrap. period still reports the exact latest interval.
- Undefined: a match requires exact equality.

Decomposition:
- Package pulse_meter_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_LOCKED} meter_state_t;
  - the saturating-max helper function.
- One natural sub-module: rising_edge_detect (clk, rst, in, edge), shared with other synchronous-input blocks.

Test Plan:
1. Hold rst=0 for 2 cycles with pulse_in toggling. Expect all outputs 0 and no period_valid.
2. ena=1; one-cycle pulses every 10 cycles for 5 pulses. Expect period_valid on the cycle after pulses 2..5, each with period=10. locked rises at pulse 4 (LOCK_COUNT=3) and stays 1.
3. While locked, one interval of 11, then 10s. Expect period=11 and locked drops to 0 on that update. Relock after three more intervals of 10. With PULSE_METER_JITTER_EN defined, locked stays 1 throughout.
4. Stop pulses after lock (N=8). Expect a single-cycle timeout exactly 255 cycles after the last edge, then locked=0 and state IDLE. The next edge produces no period_valid.
5. Intervals of 255 (edge at cnt==MAX). Expect period=255 and no timeout. Also hold pulse_in high for 20 cycles: it counts as one edge.
6. Deassert ena for 7 cycles mid-interval, with a pulse during the freeze. Expect the pulse ignored, outputs frozen, and the next measured period equal to the pre-freeze count plus the post-freeze cycles. Also assert rst mid-interval and expect an IDLE restart.
